// File: rtl/axil_fft_regbank_pkg.sv
// Shared types and register-map constants for the FFT AXI4-Lite register bank.
// Optional feature macro: AXIL_FFT_REGBANK_ERR_RESP_EN (SLVERR on unmapped index).
package axil_fft_regbank_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    // Register indices (word index = ADDR[ADDR_WIDTH-1:ADDR_LSB])
    localparam int REG_CTRL     = 0;
    localparam int REG_STATUS   = 1;
    localparam int REG_CFG_BASE = 2;

    // CTRL bit positions
    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    // STATUS bit positions
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;
    localparam int STAT_ERR_BIT  = 2;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_A,
        W_HAVE_D,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_VALID
    } rd_state_t;

endpackage

// File: rtl/axil_fft_strb_merge.sv
// Byte-lane merge: each byte takes new data when its strobe is set, else keeps old.
module axil_fft_strb_merge
    import axil_fft_regbank_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   old_data,
    input  logic [DATA_WIDTH-1:0]   new_data,
    input  logic [DATA_WIDTH/8-1:0] strb,
    output logic [DATA_WIDTH-1:0]   merged
);

    for (genvar b = 0; b < DATA_WIDTH/8; b++) begin : g_lane
        assign merged[8*b +: 8] = strb[b] ? new_data[8*b +: 8] : old_data[8*b +: 8];
    end

endmodule

// File: rtl/axil_fft_regbank.sv
// AXI4-Lite register bank in front of the FFT core: CTRL (START pulse, IRQ_EN),
// STATUS (BUSY mirror, sticky W1C DONE/ERR), and NUM_REGS-2 plain RW config words.
// Optional feature macro: AXIL_FFT_REGBANK_ERR_RESP_EN -- unmapped indices answer
// SLVERR instead of OKAY; in both builds such accesses change no state and read 0.
module axil_fft_regbank
    import axil_fft_regbank_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_REGS   = 8
) (
    input  logic                             ACLK,
    input  logic                             ARESET,
    input  logic [ADDR_WIDTH-1:0]            S_AXI_AWADDR,
    input  logic [2:0]                       S_AXI_AWPROT,
    input  logic                             S_AXI_AWVALID,
    output logic                             S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]            S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
    input  logic                             S_AXI_WVALID,
    output logic                             S_AXI_WREADY,
    output logic [1:0]                       S_AXI_BRESP,
    output logic                             S_AXI_BVALID,
    input  logic                             S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]            S_AXI_ARADDR,
    input  logic [2:0]                       S_AXI_ARPROT,
    input  logic                             S_AXI_ARVALID,
    output logic                             S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]            S_AXI_RDATA,
    output logic [1:0]                       S_AXI_RRESP,
    output logic                             S_AXI_RVALID,
    input  logic                             S_AXI_RREADY,
    input  logic                             fft_busy,
    input  logic                             fft_done,
    output logic                             start_pulse,
    output logic                             irq,
    output logic [(NUM_REGS-2)*DATA_WIDTH-1:0] cfg_regs
);

    localparam int ADDR_LSB = $clog2(DATA_WIDTH/8);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam int STRB_W   = DATA_WIDTH/8;
    localparam int NUM_CFG  = NUM_REGS - REG_CFG_BASE;

    // ---------------- register state ----------------
    logic                              irq_en_q, done_q, err_q, start_q, irq_q;
    logic [NUM_CFG-1:0][DATA_WIDTH-1:0] cfg_q;

    // ---------------- write channel ----------------
    wr_state_t             wr_state;
    logic                  awready_q, wready_q, bvalid_q;
    resp_t                 bresp_q;
    logic [IDX_W-1:0]      awidx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;

    logic                  aw_hs, w_hs, wr_commit, wr_in_range, wr_we;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_data, wr_old, wr_merged;
    logic [STRB_W-1:0]     wr_strb;
    resp_t                 wr_resp;

    assign aw_hs = S_AXI_AWVALID & awready_q;
    assign w_hs  = S_AXI_WVALID & wready_q;

    // The write lands on the cycle the second of AW/W is taken; operands come
    // from the latch for the channel that arrived earlier, else from the bus.
    assign wr_commit = (aw_hs | (wr_state == W_HAVE_A)) & (w_hs | (wr_state == W_HAVE_D));
    assign wr_idx    = (wr_state == W_HAVE_A) ? awidx_q : S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
    assign wr_data   = (wr_state == W_HAVE_D) ? wdata_q : S_AXI_WDATA;
    assign wr_strb   = (wr_state == W_HAVE_D) ? wstrb_q : S_AXI_WSTRB;

    assign wr_in_range = int'(wr_idx) < NUM_REGS;
    assign wr_we       = wr_commit & wr_in_range;

    // Current value of the targeted register, as seen by the byte merge
    always_comb begin
        wr_old = '0;
        if (wr_idx == IDX_W'(REG_CTRL)) wr_old[CTRL_IRQ_EN_BIT] = irq_en_q;
        for (int i = 0; i < NUM_CFG; i++)
            if (wr_idx == IDX_W'(i + REG_CFG_BASE)) wr_old = cfg_q[i];
    end

    axil_fft_strb_merge #(.DATA_WIDTH(DATA_WIDTH)) u_wr_merge (
        .old_data (wr_old),
        .new_data (wr_data),
        .strb     (wr_strb),
        .merged   (wr_merged)
    );

    // ---------------- read channel decode ----------------
    rd_state_t             rd_state;
    logic                  arready_q, rvalid_q;
    resp_t                 rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q, rd_val;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_in_range;
    resp_t                 rd_resp;

    assign rd_idx      = S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];
    assign rd_in_range = int'(rd_idx) < NUM_REGS;

`ifdef AXIL_FFT_REGBANK_ERR_RESP_EN
    assign wr_resp = wr_in_range ? OKAY : SLVERR;
    assign rd_resp = rd_in_range ? OKAY : SLVERR;
`else
    assign wr_resp = OKAY;
    assign rd_resp = OKAY;
`endif

    // Read mux; unmapped indices and unused bits read as zero
    always_comb begin
        rd_val = '0;
        if (rd_in_range) begin
            if (rd_idx == IDX_W'(REG_CTRL)) begin
                rd_val[CTRL_IRQ_EN_BIT] = irq_en_q;
            end else if (rd_idx == IDX_W'(REG_STATUS)) begin
                rd_val[STAT_BUSY_BIT] = fft_busy;
                rd_val[STAT_DONE_BIT] = done_q;
                rd_val[STAT_ERR_BIT]  = err_q;
            end
            for (int i = 0; i < NUM_CFG; i++)
                if (rd_idx == IDX_W'(i + REG_CFG_BASE)) rd_val = cfg_q[i];
        end
    end

    // ---------------- register side effects ----------------
    logic ctrl_we, stat_we, start_req, clr_done, clr_err;

    assign ctrl_we   = wr_we & (wr_idx == IDX_W'(REG_CTRL));
    assign stat_we   = wr_we & (wr_idx == IDX_W'(REG_STATUS));
    // All CTRL/STATUS control bits live in byte lane 0
    assign start_req = ctrl_we & wr_strb[0] & wr_data[CTRL_START_BIT];
    assign clr_done  = stat_we & wr_strb[0] & wr_data[STAT_DONE_BIT];
    assign clr_err   = stat_we & wr_strb[0] & wr_data[STAT_ERR_BIT];

    // Write FSM: independent AW/W capture, one outstanding write, registered readies
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_state  <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            awidx_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            unique case (wr_state)
                W_IDLE: begin
                    if (aw_hs && w_hs) begin
                        wr_state  <= W_RESP;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= wr_resp;
                    end else if (aw_hs) begin
                        wr_state  <= W_HAVE_A;
                        awready_q <= 1'b0;
                        awidx_q   <= S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
                    end else if (w_hs) begin
                        wr_state <= W_HAVE_D;
                        wready_q <= 1'b0;
                        wdata_q  <= S_AXI_WDATA;
                        wstrb_q  <= S_AXI_WSTRB;
                    end
                end
                W_HAVE_A: begin
                    if (w_hs) begin
                        wr_state <= W_RESP;
                        wready_q <= 1'b0;
                        bvalid_q <= 1'b1;
                        bresp_q  <= wr_resp;
                    end
                end
                W_HAVE_D: begin
                    if (aw_hs) begin
                        wr_state  <= W_RESP;
                        awready_q <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= wr_resp;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        wr_state  <= W_IDLE;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // Register bank: START pulse, sticky DONE/ERR (set beats clear), config words, irq
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            irq_q    <= 1'b0;
            cfg_q    <= '0;
        end else begin
            start_q <= start_req & ~fft_busy;
            if (ctrl_we) irq_en_q <= wr_merged[CTRL_IRQ_EN_BIT];
            done_q <= fft_done | (done_q & ~clr_done);
            err_q  <= (start_req & fft_busy) | (err_q & ~clr_err);
            irq_q  <= irq_en_q & (done_q | err_q);
            for (int i = 0; i < NUM_CFG; i++)
                if (wr_we && wr_idx == IDX_W'(i + REG_CFG_BASE)) cfg_q[i] <= wr_merged;
        end
    end

    // Read FSM: capture data at AR handshake, hold RVALID/RDATA until RREADY
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rd_state  <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
        end else begin
            unique case (rd_state)
                R_IDLE: begin
                    if (S_AXI_ARVALID && arready_q) begin
                        rd_state  <= R_VALID;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= rd_val;
                        rresp_q   <= rd_resp;
                    end
                end
                R_VALID: begin
                    if (S_AXI_RREADY) begin
                        rd_state  <= R_IDLE;
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // Protection bits and sub-word address bits carry no meaning here
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign start_pulse   = start_q;
    assign irq           = irq_q;
    assign cfg_regs      = cfg_q;

endmodule

// File: tb/tb_axil_fft_regbank.sv
// Self-checking bench for axil_fft_regbank: directed register-map scenarios plus
// randomized traffic against a behavioural register model.
module tb_axil_fft_regbank;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NR = 8;
    localparam int SW = DW/8;

`ifdef AXIL_FFT_REGBANK_ERR_RESP_EN
    localparam logic [1:0] BAD_RESP = 2'b10;
`else
    localparam logic [1:0] BAD_RESP = 2'b00;
`endif

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    logic [AW-1:0] S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
    logic [2:0]    S_AXI_AWPROT = '0, S_AXI_ARPROT = '0;
    logic          S_AXI_AWVALID = 0, S_AXI_WVALID = 0, S_AXI_BREADY = 0;
    logic          S_AXI_ARVALID = 0, S_AXI_RREADY = 0;
    logic [DW-1:0] S_AXI_WDATA = '0;
    logic [SW-1:0] S_AXI_WSTRB = '0;
    logic          S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
    logic [1:0]    S_AXI_BRESP, S_AXI_RRESP;
    logic [DW-1:0] S_AXI_RDATA;
    logic          fft_busy = 0, fft_done = 0;
    logic          start_pulse, irq;
    logic [(NR-2)*DW-1:0] cfg_regs;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model of the architectural register state
    logic [DW-1:0] m_cfg [NR];
    bit m_irq_en, m_done, m_err;

    axil_fft_regbank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .fft_busy(fft_busy), .fft_done(fft_done),
        .start_pulse(start_pulse), .irq(irq), .cfg_regs(cfg_regs)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- model ----------------
    task automatic mdl_reset();
        for (int i = 0; i < NR; i++) m_cfg[i] = '0;
        m_irq_en = 0; m_done = 0; m_err = 0;
    endtask

    function automatic logic [DW-1:0] mdl_read(input int idx, input bit busy);
        logic [DW-1:0] r;
        r = '0;
        if (idx == 0)       r[1] = m_irq_en;
        else if (idx == 1)  r[2:0] = {m_err, m_done, busy};
        else if (idx < NR)  r = m_cfg[idx];
        return r;
    endfunction

    task automatic mdl_write(input int idx, input logic [DW-1:0] d, input logic [SW-1:0] s,
                             input bit busy, input bit done_now, output bit st);
        st = 0;
        if (idx == 0) begin
            if (s[0]) begin
                m_irq_en = d[1];
                if (d[0]) begin
                    if (busy) m_err = 1;
                    else      st = 1;
                end
            end
        end else if (idx == 1) begin
            if (s[0]) begin
                if (d[1]) m_done = 0;
                if (d[2]) m_err = 0;
            end
        end else if (idx < NR) begin
            for (int b = 0; b < SW; b++)
                if (s[b]) m_cfg[idx][8*b +: 8] = d[8*b +: 8];
        end
        if (done_now) m_done = 1;
    endtask

    // ---------------- bus tasks (drive and sample on negedge) ----------------
    task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] d,
                             input logic [SW-1:0] s, input int aw_dly, input int w_dly,
                             input int b_dly, input bit done_now, input bit exp_start,
                             output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_go, w_go;
        int cyc = 0;
        int k = 0;
        while (!(aw_done && w_done)) begin
            @(negedge ACLK);
            if (cyc > 60) begin chk("wr_accept_timeout", 0, 1); break; end
            S_AXI_AWVALID = !aw_done && cyc >= aw_dly;
            S_AXI_AWADDR  = addr;
            S_AXI_WVALID  = !w_done && cyc >= w_dly;
            S_AXI_WDATA   = d;
            S_AXI_WSTRB   = s;
            aw_go = S_AXI_AWVALID && S_AXI_AWREADY;
            w_go  = S_AXI_WVALID && S_AXI_WREADY;
            fft_done = done_now && (aw_done || aw_go) && (w_done || w_go);
            @(posedge ACLK);
            aw_done |= aw_go;
            w_done  |= w_go;
            cyc++;
        end
        @(negedge ACLK);
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0; fft_done = 0;
        chk("bvalid_latency", S_AXI_BVALID, 1);
        chk("start_pulse", start_pulse, exp_start);
        while (k < 40) begin
            S_AXI_BREADY = (k >= b_dly);
            chk("bvalid_hold", S_AXI_BVALID, 1);
            if (S_AXI_BREADY) break;
            chk("awready_blocked", S_AXI_AWREADY, 0);
            chk("wready_blocked", S_AXI_WREADY, 0);
            @(posedge ACLK); @(negedge ACLK);
            k++;
        end
        resp = S_AXI_BRESP;
        @(posedge ACLK); @(negedge ACLK);
        S_AXI_BREADY = 0;
        chk("bvalid_clear", S_AXI_BVALID, 0);
        chk("start_clear", start_pulse, 0);
        chk("awready_back", S_AXI_AWREADY, 1);
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input int r_dly,
                            output logic [DW-1:0] d, output logic [1:0] resp);
        logic [DW-1:0] first;
        int k = 0;
        @(negedge ACLK);
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1;
        chk("arready_idle", S_AXI_ARREADY, 1);
        @(posedge ACLK); @(negedge ACLK);
        S_AXI_ARVALID = 0;
        chk("rvalid_latency", S_AXI_RVALID, 1);
        first = S_AXI_RDATA;
        while (k < 40) begin
            S_AXI_RREADY = (k >= r_dly);
            chk("rvalid_hold", S_AXI_RVALID, 1);
            chk("rdata_stable", S_AXI_RDATA, first);
            if (S_AXI_RREADY) break;
            @(posedge ACLK); @(negedge ACLK);
            k++;
        end
        d = S_AXI_RDATA; resp = S_AXI_RRESP;
        @(posedge ACLK); @(negedge ACLK);
        S_AXI_RREADY = 0;
        chk("rvalid_clear", S_AXI_RVALID, 0);
        chk("arready_back", S_AXI_ARREADY, 1);
    endtask

    task automatic do_write(input int idx, input logic [DW-1:0] d, input logic [SW-1:0] s,
                            input int aw_dly, input int w_dly, input int b_dly, input bit done_now);
        bit st;
        logic [1:0] resp;
        logic [AW-1:0] addr;
        addr = AW'(idx * 4 + int'($urandom_range(0, 3)));
        mdl_write(idx, d, s, fft_busy, done_now, st);
        axi_write(addr, d, s, aw_dly, w_dly, b_dly, done_now, st, resp);
        chk("bresp", resp, (idx < NR) ? 2'b00 : BAD_RESP);
    endtask

    task automatic do_read(input int idx, input int r_dly, output logic [DW-1:0] d);
        logic [1:0] resp;
        logic [DW-1:0] exp;
        exp = mdl_read(idx, fft_busy);
        axi_read(AW'(idx * 4 + int'($urandom_range(0, 3))), r_dly, d, resp);
        chk("rdata", d, exp);
        chk("rresp", resp, (idx < NR) ? 2'b00 : BAD_RESP);
    endtask

    task automatic pulse_done();
        @(negedge ACLK); fft_done = 1;
        @(negedge ACLK); fft_done = 0;
        @(negedge ACLK);
        m_done = 1;
    endtask

    task automatic check_state();
        chk("irq", irq, m_irq_en & (m_done | m_err));
        for (int i = 0; i < NR - 2; i++)
            chk("cfg_regs", cfg_regs[i*DW +: DW], m_cfg[i+2]);
    endtask

    task automatic check_reset_outputs();
        chk("rst_awready", S_AXI_AWREADY, 1);
        chk("rst_wready", S_AXI_WREADY, 1);
        chk("rst_arready", S_AXI_ARREADY, 1);
        chk("rst_bvalid", S_AXI_BVALID, 0);
        chk("rst_rvalid", S_AXI_RVALID, 0);
        chk("rst_bresp", S_AXI_BRESP, 0);
        chk("rst_rresp", S_AXI_RRESP, 0);
        chk("rst_rdata", S_AXI_RDATA, 0);
        chk("rst_start", start_pulse, 0);
        chk("rst_irq", irq, 0);
        chk("rst_cfg", cfg_regs, 0);
    endtask

    initial begin
        logic [DW-1:0] rd;
        mdl_reset();
        repeat (3) @(negedge ACLK);
        ARESET = 0;
        @(negedge ACLK);
        check_reset_outputs();

        // basic write / readback of config words
        for (int i = 0; i < 4; i++) do_write(2 + i, DW'(i + 1), '1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            do_read(2 + i, 0, rd);
            chk("basic_lit", rd, DW'(i + 1));
        end

        // AW/W skew and B back-pressure
        do_write(5, 32'hCAFE0001, '1, 3, 0, 0, 0);
        do_write(6, 32'hCAFE0002, '1, 0, 3, 0, 0);
        do_write(7, 32'hCAFE0003, '1, 0, 0, 5, 0);
        for (int i = 5; i < 8; i++) do_read(i, 2, rd);
        check_state();

        // byte strobes
        do_write(2, 32'hAABBCCDD, '1, 0, 0, 0, 0);
        do_write(2, 32'h11223344, 4'b0101, 1, 0, 0, 0);
        do_read(2, 0, rd);
        chk("strb_lit", rd, 32'hAA22CC44);

        // START, DONE, irq, W1C, set-beats-clear
        fft_busy = 0;
        do_write(0, 32'h3, '1, 0, 0, 0, 0);
        check_state();
        pulse_done();
        do_read(1, 0, rd);
        chk("status_done_lit", rd, 32'h2);
        chk("irq_done_lit", irq, 1);
        do_write(1, 32'h2, '1, 0, 0, 0, 0);
        do_read(1, 0, rd);
        chk("status_clr_lit", rd, 32'h0);
        chk("irq_clr_lit", irq, 0);
        do_write(1, 32'h2, '1, 2, 0, 0, 1);
        do_read(1, 0, rd);
        chk("set_wins_lit", rd, 32'h2);
        do_write(1, 32'h2, '1, 0, 0, 0, 0);

        // START while busy -> ERR, no pulse
        fft_busy = 1;
        do_write(0, 32'h3, '1, 0, 0, 0, 0);
        do_read(1, 0, rd);
        chk("start_busy_lit", rd, 32'h5);
        check_state();
        fft_busy = 0;
        do_write(1, 32'h4, 4'b1110, 0, 0, 0, 0);  // lane 0 disabled: ERR must stay
        do_write(1, 32'h4, '1, 0, 0, 0, 0);
        check_state();

        // unmapped index
        do_write(NR, 32'hFFFF_FFFF, '1, 0, 0, 0, 0);
        do_read(NR, 0, rd);
        chk("unmapped_rdata_lit", rd, 0);
        for (int i = 0; i < NR; i++) do_read(i, 0, rd);
        check_state();

        // randomized traffic
        repeat (150) begin
            int op, idx;
            op = int'($urandom_range(0, 9));
            idx = int'($urandom_range(0, NR + 1));
            fft_busy = ($urandom_range(0, 3) == 0);
            if (op < 5)
                do_write(idx, $urandom, SW'($urandom), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                         $urandom_range(0, 7) == 0);
            else if (op < 9)
                do_read(idx, int'($urandom_range(0, 2)), rd);
            else
                pulse_done();
            check_state();
        end
        fft_busy = 0;

        // reset in the middle of a pending write and a pending read
        @(negedge ACLK);
        S_AXI_AWADDR = 6'h08; S_AXI_AWVALID = 1;
        @(posedge ACLK); @(negedge ACLK);
        S_AXI_AWVALID = 0;
        S_AXI_ARADDR = 6'h0C; S_AXI_ARVALID = 1;
        @(posedge ACLK); @(negedge ACLK);
        S_AXI_ARVALID = 0;
        chk("pre_reset_rvalid", S_AXI_RVALID, 1);
        ARESET = 1;
        #1;
        chk("async_rvalid_drop", S_AXI_RVALID, 0);
        chk("async_awready", S_AXI_AWREADY, 1);
        mdl_reset();
        @(negedge ACLK);
        ARESET = 0;
        @(negedge ACLK);
        check_reset_outputs();
        do_write(3, 32'h5A5A5A5A, '1, 0, 0, 0, 0);
        do_read(2, 0, rd);
        do_read(3, 0, rd);
        check_state();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
